// File: rtl/rv_tb_pkg.sv
// Shared types and default constants for the store monitor.
//   verdict_e     : verdict encoding exposed on store_monitor.verdict
//   store_entry_t : one captured store {addr, data}
//   DEF_*         : default FIFO depth, signature address/value, cycle budget
package rv_tb_pkg;

    typedef enum logic [1:0] {
        V_RUN     = 2'd0,
        V_PASS    = 2'd1,
        V_FAIL    = 2'd2,
        V_TIMEOUT = 2'd3
    } verdict_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    localparam int          DEF_DEPTH     = 8;
    localparam logic [31:0] DEF_PASS_ADDR = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA = 32'd25;
    localparam logic [31:0] DEF_TIMEOUT   = 32'd1000;

endpackage

// File: rtl/store_fifo.sv
// Show-ahead FIFO holding captured stores.
//   clk, reset (async, active-low)
//   push/wdata : write request; ignored when full unless a pop happens on the same edge
//   pop        : remove head; ignored when empty
//   full/empty : occupancy flags
//   head       : current head entry, all-zero while empty
module store_fifo
    import rv_tb_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = store_entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    T            mem [DEPTH];
    T            zero_entry;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra MSB on each pointer tells full (wrap bits differ) from empty.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push    = push && (!full || do_pop);
    assign zero_entry = '0;
    assign head       = empty ? zero_entry : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/store_monitor.sv
// Captures core data stores into a log FIFO and decides a run verdict.
//   clk, reset (async, active-low), en (core enable)
//   MemWrite/DataAdr/WriteData : core store port
//   log_ready / log_valid, log_addr, log_data : show-ahead log stream
//   store_count (saturating), cycle_count (enabled RUN cycles, saturating)
//   overflow (sticky drop flag), done, pass, verdict
//
// state     | meaning
// ----------+--------------------------------------------------------
// V_RUN     | capturing stores and counting enabled cycles
// V_PASS    | signature address written with the pass value (terminal)
// V_FAIL    | signature address written with any other value (terminal)
// V_TIMEOUT | cycle budget exhausted without a signature (terminal)
module store_monitor
    import rv_tb_pkg::*;
#(
    parameter int          DEPTH     = DEF_DEPTH,
    parameter logic [31:0] PASS_ADDR = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA = DEF_PASS_DATA,
    parameter logic [31:0] TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        log_ready,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic        overflow,
    output logic        done,
    output logic        pass,
    output logic [1:0]  verdict
);

    verdict_e     state_q;
    verdict_e     state_d;
    store_entry_t wr_entry;
    store_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         capture;
    logic         pop;
    logic         sig_hit;
    logic         timeout_hit;

    assign capture     = en && MemWrite && (state_q == V_RUN);
    assign pop         = log_valid && log_ready;
    assign sig_hit     = capture && (DataAdr == PASS_ADDR);
    assign timeout_hit = en && (state_q == V_RUN) && (cycle_count == TIMEOUT - 32'd1);
    assign wr_entry    = '{addr: DataAdr, data: WriteData};

    store_fifo #(
        .DEPTH (DEPTH),
        .T     (store_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .wdata (wr_entry),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign log_valid = !fifo_empty;
    assign log_addr  = head.addr;
    assign log_data  = head.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_count <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
        end else begin
            // Dropped stores are still counted.
            if (capture && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
            if (en && state_q == V_RUN && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;
            if (capture && fifo_full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= V_RUN;
        else        state_q <= state_d;
    end

    // Signature store takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        if (state_q == V_RUN) begin
            if (sig_hit)
                state_d = (WriteData == PASS_DATA) ? V_PASS : V_FAIL;
            else if (timeout_hit)
                state_d = V_TIMEOUT;
        end
    end

    always_comb begin
        verdict = state_q;
        done    = (state_q != V_RUN);
        pass    = (state_q == V_PASS);
    end

endmodule

// File: doc/store_monitor.md
# store_monitor

Simulation-side responder for the core's data-store port (`MemWrite`, `DataAdr`, `WriteData`) exported by `RV_wrapper`. It captures every store the core issues, buffers it in a small FIFO for a log/scoreboard consumer, and runs a verdict state machine. The state machine declares pass or fail from the harness signature store, or declares timeout from a cycle budget. It sits beside `RV_wrapper` in the bench and replaces ad-hoc per-cycle checks with a registered, reusable checker.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `PASS_ADDR`, 32'd100: signature address.
- `PASS_DATA`, 32'd25: value that signals pass when written to `PASS_ADDR`.
- `TIMEOUT`, 32'd1000: cycle budget counted in enabled cycles.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `en` in 1: core enable; gates capture and cycle counting.
- `MemWrite` in 1: core store strobe.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `log_ready` in 1: consumer accepts the head entry.
- `log_valid` out 1: FIFO non-empty.
- `log_addr` out 32: head entry address.
- `log_data` out 32: head entry data.
- `store_count` out 16: captured stores, saturating.
- `cycle_count` out 32: enabled cycles spent in RUN, saturating.
- `overflow` out 1: sticky; set when a store is dropped.
- `done` out 1: verdict reached.
- `pass` out 1: verdict is PASS.
- `verdict` out 2: RUN=0, PASS=1, FAIL=2, TIMEOUT=3.

## Operation
- Capture happens on a rising edge with `en & MemWrite & verdict==RUN`.
- Each capture pushes {`DataAdr`, `WriteData`} and increments `store_count`. The count saturates at 16'hFFFF.
- FIFO is show-ahead: `log_valid = !empty`, and `log_addr`/`log_data` present the head entry.
- Pop occurs on any edge where `log_valid & log_ready`.
- Full FIFO with push and no pop: the entry is dropped, `overflow` is set, and `store_count` still increments.
- Full FIFO with push and pop in the same cycle: both occur and nothing is dropped.
- Empty FIFO with push and `log_ready` high: no pop; the entry appears next cycle.
- Verdict FSM, from RUN:
  - Capture with addr==`PASS_ADDR` and data==`PASS_DATA` → PASS.
  - Capture with addr==`PASS_ADDR` and any other data → FAIL.
  - `cycle_count` reaching `TIMEOUT`-1 on an enabled edge → TIMEOUT.
- Simultaneous signature store and timeout edge: the store's verdict (PASS or FAIL) wins.
- PASS, FAIL and TIMEOUT are terminal and held until `reset`.
- The signature store itself is logged. Later stores are not captured. The FIFO keeps draining.
- `done = (verdict != RUN)`; `pass = (verdict == PASS)`.
- `cycle_count` increments on edges with `en` while in RUN. It freezes once a verdict is reached.

## Timing
- Reset values, forced asynchronously while `reset` is low:
  - verdict=RUN, done=0, pass=0, overflow=0.
  - store_count=0, cycle_count=0.
  - FIFO empty, log_valid=0, log_addr=0, log_data=0.
- Reset mid-operation discards all FIFO contents and all counts immediately.
- Capture latency: a store sampled at edge k shows `log_valid`/`log_addr`/`log_data` after edge k (next cycle), provided the FIFO was empty.
- Verdict latency: `done`/`pass` are registered and assert after the capturing edge.
- No combinational path from `MemWrite` to any output.
- `en`=0 freezes capture and `cycle_count` only; the FIFO still drains.
- Pointer wrap-around uses DEPTH-modulo pointers plus an extra wrap bit for the full/empty distinction.

## Structure
- Package `rv_tb_pkg`:
  - `verdict_e` enum (RUN, PASS, FAIL, TIMEOUT).
  - `store_entry_t` struct {addr[31:0], data[31:0]}.
  - Default signature constants.
- Sub-module `store_fifo`: parameterized by DEPTH and entry type. Ports push/pop/full/empty, head data out. Same async active-low `reset`.
- Top `store_monitor` holds the capture qualification, the counters and the verdict FSM.

## Test plan
- Reset held for 2 cycles with `MemWrite`=1 → no captures, all outputs at reset values. Release, then store (8, 7) → next cycle `log_valid`=1, `log_addr`=8, `log_data`=7, `store_count`=1.
- Stores (4,1), (8,2), (100,25) with `log_ready`=1 → three log entries in order, `done`=1, `pass`=1, `verdict`=1. A further store (12,3) → not captured, `store_count` stays 3.
- Store (100, 26) → `verdict`=2, `pass`=0, `done`=1.
- `log_ready`=0, DEPTH=8, 10 stores → first 8 retained, `overflow`=1, `store_count`=10. Push and pop on the same edge while full → no additional drop.
- No signature store, `TIMEOUT`=50 → `verdict`=3 after the 50th enabled edge. `en` low for 5 cycles mid-run delays TIMEOUT by exactly 5 cycles.
- Signature store on the edge where `cycle_count` hits the budget → PASS. Assert `reset` low mid-run with 3 entries queued → `log_valid`=0 and counts=0 immediately, without waiting for a clock edge.
